pipe_stage_chain: RTL and testbench

- Parametrised successor to the fixed decode-to-execute latch: a chain of DEPTH identical pipeline registers carrying a WIDTH-bit payload, a valid bit and an SB_W-bit sideband.
- Each stage obeys the global stall vector at its own index, with flush and bubble insertion.
- Sits between any two pipeline stages driven by the central stall/flush controller, for example id->ex or a multi-cycle ex->mem split.
- Sideband bits survive a bubble, in the same way the delay-slot feedback flag does, so state fed back to earlier stages is not lost.

---
 rtl/pipe_stage_chain.sv | 136 +++++++++++++
 tb/tb_pipe_stage_chain.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_chain
// Description : Chain of DEPTH identical pipeline registers carrying a
//               WIDTH-bit payload, a valid bit and an SB_W-bit sideband.
//               Stage k obeys stall[STAGE+k] (stop) and stall[STAGE+k+1]
//               (next). Per-edge priority is rst > flush > bubble > hold >
//               advance. A bubble clears valid and payload but keeps the
//               sideband, so feedback state such as a delay-slot flag is
//               not lost.
// Ports       : clk, rst (sync, active-high)
//               stall[STALL_W]  stall vector, 1 = stop
//               flush           clears every stage
//               in_valid/in_data/in_sb     upstream stage
//               out_valid/out_data/out_sb  last stage registers
//               stage_valid[DEPTH]         valid bit of every stage
//               bubble_cnt/hold_cnt (only with PIPE_STAGE_PERF_EN defined)
// Options     : `define PIPE_STAGE_PERF_EN adds saturating 16-bit counters
//               of bubble and hold events taken by the last stage.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_chain #(
  parameter int               WIDTH     = 32,
  parameter int               SB_W      = 1,
  parameter int               DEPTH     = 1,
  parameter int               STAGE     = 2,
  parameter int               STALL_W   = 6,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SB_W-1:0]    in_sb,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SB_W-1:0]    out_sb,
  output logic [DEPTH-1:0]   stage_valid
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]        bubble_cnt,
  output logic [15:0]        hold_cnt
`endif
);

  // Every stage reads stall[STAGE+k+1], so the top stage needs one bit
  // above it in the vector.
  if ((DEPTH < 1) || (DEPTH > 4) || (STAGE + DEPTH > STALL_W - 1)) begin : g_param_check
    $error("pipe_stage_chain: illegal DEPTH/STAGE/STALL_W combination");
  end

  // Flattened view of all stage registers, used for stage chaining and outputs.
  logic [DEPTH-1:0]       v_all;
  logic [DEPTH*WIDTH-1:0] d_all;
  logic [DEPTH*SB_W-1:0]  s_all;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic              src_v;
    logic [WIDTH-1:0]  src_d;
    logic [SB_W-1:0]   src_s;
    logic              stop;
    logic              nxt;
    logic              v_r;
    logic [WIDTH-1:0]  d_r;
    logic [SB_W-1:0]   s_r;

    if (k == 0) begin : g_head
      assign src_v = in_valid;
      assign src_d = in_data;
      assign src_s = in_sb;
    end else begin : g_link
      assign src_v = v_all[k-1];
      assign src_d = d_all[(k-1)*WIDTH +: WIDTH];
      assign src_s = s_all[(k-1)*SB_W +: SB_W];
    end

    assign stop = stall[STAGE+k];
    assign nxt  = stall[STAGE+k+1];

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        v_r <= 1'b0;
        d_r <= NOP_VALUE;
        s_r <= '0;
      end else if (stop) begin
        // Downstream still moving: leave a bubble behind, sideband kept.
        if (!nxt) begin
          v_r <= 1'b0;
          d_r <= NOP_VALUE;
        end
      end else begin
        // Upstream valid copied as-is, so upstream bubbles propagate.
        v_r <= src_v;
        d_r <= src_d;
        s_r <= src_s;
      end
    end

    assign v_all[k]                 = v_r;
    assign d_all[k*WIDTH +: WIDTH]  = d_r;
    assign s_all[k*SB_W +: SB_W]    = s_r;
  end

  assign out_valid   = v_all[DEPTH-1];
  assign out_data    = d_all[(DEPTH-1)*WIDTH +: WIDTH];
  assign out_sb      = s_all[(DEPTH-1)*SB_W +: SB_W];
  assign stage_valid = v_all;

  // Only the stall bits covering this chain matter; the rest are ignored.
  logic unused_stall;
  assign unused_stall = ^stall;

`ifdef PIPE_STAGE_PERF_EN
  logic last_bubble;
  logic last_hold;

  assign last_bubble = stall[STAGE+DEPTH-1] & ~stall[STAGE+DEPTH];
  assign last_hold   = stall[STAGE+DEPTH-1] &  stall[STAGE+DEPTH];

  // A flush overrides the branch, so flush edges are not counted;
  // the counters themselves survive a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= 16'd0;
      hold_cnt   <= 16'd0;
    end else if (!flush) begin
      if (last_bubble && (bubble_cnt != 16'hFFFF)) bubble_cnt <= bubble_cnt + 16'd1;
      if (last_hold && (hold_cnt != 16'hFFFF))     hold_cnt   <= hold_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_chain
// Description : Self-checking bench for pipe_stage_chain (DEPTH=3, STAGE=2,
//               STALL_W=6, non-zero NOP payload). A reference model of the
//               stage contents is updated once per clock edge and compared
//               with the DUT outputs 1 ns after every edge. Directed steps
//               cover reset, latency, bubble, hold, flush and reset-in-hold;
//               a randomized section mixes monotone and arbitrary stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_chain;
  localparam int          WIDTH   = 16;
  localparam int          SB_W    = 2;
  localparam int          DEPTH   = 3;
  localparam int          STAGE   = 2;
  localparam int          STALL_W = 6;
  localparam logic [15:0] NOP     = 16'hDEAD;

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               in_valid;
  logic [WIDTH-1:0]   in_data;
  logic [SB_W-1:0]    in_sb;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SB_W-1:0]    out_sb;
  logic [DEPTH-1:0]   stage_valid;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]        bubble_cnt;
  logic [15:0]        hold_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: contents of each stage, plus expected counters.
  logic             mv [DEPTH];
  logic [WIDTH-1:0] md [DEPTH];
  logic [SB_W-1:0]  ms [DEPTH];
  int               m_bub;
  int               m_hold;

  pipe_stage_chain #(
    .WIDTH(WIDTH), .SB_W(SB_W), .DEPTH(DEPTH), .STAGE(STAGE),
    .STALL_W(STALL_W), .NOP_VALUE(NOP)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_sb(in_sb),
    .out_valid(out_valid), .out_data(out_data), .out_sb(out_sb),
    .stage_valid(stage_valid)
`ifdef PIPE_STAGE_PERF_EN
    , .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_edge();
    bit stop, nxt;
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin mv[k] = 0; md[k] = NOP; ms[k] = '0; end
      m_bub = 0; m_hold = 0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin mv[k] = 0; md[k] = NOP; ms[k] = '0; end
    end else begin
      // Walk from the last stage down so each stage sees old upstream values.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        stop = stall[STAGE+k];
        nxt  = stall[STAGE+k+1];
        if (!stop) begin
          mv[k] = (k == 0) ? in_valid : mv[k-1];
          md[k] = (k == 0) ? in_data  : md[k-1];
          ms[k] = (k == 0) ? in_sb    : ms[k-1];
        end else if (!nxt) begin
          mv[k] = 0;
          md[k] = NOP;
          if (k == DEPTH - 1 && m_bub < 65535) m_bub++;
        end else begin
          if (k == DEPTH - 1 && m_hold < 65535) m_hold++;
        end
      end
    end
  endtask

  task automatic tick(input string tag);
    logic [DEPTH-1:0] sv;
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < DEPTH; k++) sv[k] = mv[k];
    chk({tag, ".out_valid"},   32'(out_valid),   32'(mv[DEPTH-1]));
    chk({tag, ".out_data"},    32'(out_data),    32'(md[DEPTH-1]));
    chk({tag, ".out_sb"},      32'(out_sb),      32'(ms[DEPTH-1]));
    chk({tag, ".stage_valid"}, 32'(stage_valid), 32'(sv));
`ifdef PIPE_STAGE_PERF_EN
    chk({tag, ".bubble_cnt"},  32'(bubble_cnt),  32'(m_bub));
    chk({tag, ".hold_cnt"},    32'(hold_cnt),    32'(m_hold));
`endif
  endtask

  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input logic [SB_W-1:0] s);
    in_valid = v; in_data = d; in_sb = s;
  endtask

  initial begin
    logic [6:0] therm;
    for (int k = 0; k < DEPTH; k++) begin mv[k] = 0; md[k] = NOP; ms[k] = '0; end
    m_bub = 0; m_hold = 0;
    rst = 1; flush = 0; stall = '0;
    drive(1, 16'h1234, 2'b11);

    // Reset state
    tick("reset");
    tick("reset");
    chk("reset.const_data", 32'(out_data), 32'(NOP));
    chk("reset.const_valid", 32'(stage_valid), 32'd0);
    rst = 0;

    // Latency DEPTH with stall clear
    drive(1, 16'h0011, 2'b01); tick("lat");
    drive(1, 16'h0022, 2'b10); tick("lat");
    drive(1, 16'h0033, 2'b11); tick("lat");
    chk("lat.first", 32'(out_data), 32'h0011);
    drive(0, 16'h0044, 2'b00); tick("lat");
    chk("lat.second", 32'(out_data), 32'h0022);
    tick("lat");
    chk("lat.third", 32'(out_data), 32'h0033);
    chk("lat.third_valid", 32'(out_valid), 32'd1);

    // Fill all stages with valid data, sideband 1
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 16'(16'hA000 + i), 2'b01);
      tick("fill");
    end

    // Bubble in the last stage only: sideband must survive
    stall = 6'b011100; tick("bubble");
    chk("bubble.valid", 32'(out_valid), 32'd0);
    chk("bubble.data", 32'(out_data), 32'(NOP));
    chk("bubble.sb", 32'(out_sb), 32'd1);

    // Hold everything for three edges
    stall = 6'b000000; drive(1, 16'h0055, 2'b10);
    for (int i = 0; i < DEPTH; i++) tick("refill");
    stall = 6'b111100;
    for (int i = 0; i < 3; i++) begin
      tick("hold");
      chk("hold.data", 32'(out_data), 32'h0055);
    end
    stall = 6'b000000; drive(1, 16'h0066, 2'b01);
    for (int i = 0; i < DEPTH; i++) tick("release");
    chk("release.data", 32'(out_data), 32'h0066);

    // Flush beats stall
    stall = 6'b111100; flush = 1; tick("flush");
    chk("flush.stage_valid", 32'(stage_valid), 32'd0);
    chk("flush.sb", 32'(out_sb), 32'd0);
    flush = 0; stall = '0;

    // Randomized: monotone and arbitrary stall vectors, occasional flush/rst
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 16'($urandom), 2'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        stall = 6'($urandom);
      end else begin
        therm = (7'd1 << $urandom_range(0, 6)) - 7'd1;
        stall = therm[5:0];
      end
      flush = ($urandom_range(0, 29) == 0);
      rst   = ($urandom_range(0, 49) == 0);
      tick("rand");
    end
    rst = 0; flush = 0; stall = '0;

    // Reset while holding a latched payload
    drive(1, 16'h0077, 2'b11);
    for (int i = 0; i < DEPTH; i++) tick("pre_rst");
    drive(1, 16'h0088, 2'b10);
    stall = 6'b111100; tick("pre_rst_hold");
    rst = 1; tick("rst_in_hold");
    chk("rst_in_hold.data", 32'(out_data), 32'(NOP));
    chk("rst_in_hold.valid", 32'(out_valid), 32'd0);
    rst = 0; stall = '0;
    tick("post_rst");

`ifdef PIPE_STAGE_PERF_EN
    // Hold long enough to saturate the hold counter
    stall = 6'b111100;
    for (int i = 0; i < 65540; i++) tick("sat");
    chk("sat.hold_cnt", 32'(hold_cnt), 32'h0000FFFF);
    flush = 1; tick("sat_flush");
    chk("sat_flush.hold_cnt", 32'(hold_cnt), 32'h0000FFFF);
    flush = 0; stall = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
